// File: rtl/aes128_round_sequencer_if.sv
// aes128_round_sequencer_if: host-side plaintext/key in, ciphertext out handshake bundle
interface aes128_round_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext
  );
  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext
  );
endinterface

// File: rtl/aes128_round_sequencer.sv
// aes128_round_sequencer: iterative AES-128 encryptor, one shared round datapath, on-the-fly key expansion
module aes128_round_sequencer #(
  parameter int NR    = 10,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  aes128_round_sequencer_if.slave io,
  output logic                 busy,
  output logic [CNT_W-1:0]     round_idx
);
  if (NR != 10) begin : g_nr_chk
    $error("aes128_round_sequencer supports only NR = 10");
  end
  if ((1 << CNT_W) <= NR) begin : g_cnt_chk
    $error("CNT_W too narrow to hold NR");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, maps 0 to 0) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s, r;
    s = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [CNT_W-1:0] r);
    case (int'(r))
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w4, w5, w6, w7;
    w4 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    w5 = k[95:64] ^ w4;
    w6 = k[63:32] ^ w5;
    w7 = k[31:0] ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  // byte i lives at bits 127-8i; column-major, so row r of column c is byte 4c+r
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    return t;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      t[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return t;
  endfunction

  logic [1:0]       fsm_q, fsm_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic [127:0]     state_q, state_d, key_q, key_d, ct_q, ct_d;
  logic             out_valid_q, out_valid_d;
  logic [127:0]     rk, sr;

  assign rk = expand(key_q, rcon(round_q));
  assign sr = sub_shift(state_q);

  // next-state: round 0 whitening on accept, middle rounds 1..9, last round in FINAL, hold in DONE
  always_comb begin
    fsm_d       = fsm_q;
    round_d     = round_q;
    state_d     = state_q;
    key_d       = key_q;
    ct_d        = ct_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      IDLE: if (io.in_valid) begin
        state_d = io.plaintext ^ io.key;
        key_d   = io.key;
        round_d = CNT_W'(1);
        fsm_d   = ROUND;
      end
      ROUND: begin
        key_d   = rk;
        state_d = mix(sr) ^ rk;
        round_d = round_q + CNT_W'(1);
        fsm_d   = (round_q == CNT_W'(NR - 1)) ? FINAL : ROUND;
      end
      FINAL: begin
        ct_d        = sr ^ rk;
        out_valid_d = 1'b1;
        fsm_d       = DONE;
      end
      DONE: if (io.out_ready) begin
        out_valid_d = 1'b0;
        round_d     = '0;
        fsm_d       = IDLE;
      end
      default: begin
        fsm_d       = IDLE;
        round_d     = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      round_q     <= '0;
      state_q     <= '0;
      key_q       <= '0;
      ct_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      round_q     <= round_d;
      state_q     <= state_d;
      key_q       <= key_d;
      ct_q        <= ct_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io.in_ready   = fsm_q == IDLE;
  assign io.out_valid  = out_valid_q;
  assign io.ciphertext = ct_q;
  assign busy          = fsm_q != IDLE;
  assign round_idx     = round_q;
endmodule
